filtro_fir: RTL
===============

# filtro_fir

Four-tap fixed-point FIR filter stage directly downstream of the frequency divider. The divider's one-cycle sample strobe drives `Enable`, which captures one input sample into the delay line. A single multiplier-accumulator then computes the output serially, one tap per clock. The result is saturated, registered on `Y`, and flagged by a one-cycle `Done` pulse.

## Interface

Parameters:
- `WIDTH`, 12: sample and coefficient width, signed two's complement.
- `FRAC`, 8: fractional bits in samples and coefficients (Q(WIDTH-FRAC).FRAC).

Ports (reset is decided: one clock, asynchronous active-low reset):
- `CLK`, in, 1: clock; all state updates on its rising edge.
- `Reset`, in, 1: asynchronous, active-low. 0 forces the reset state immediately, independent of `CLK`.
- `Enable`, in, 1: sample strobe from the divider, one cycle wide.
- `X`, in, WIDTH: input sample, signed.
- `A0`..`A3`, in, WIDTH each: tap coefficients, signed, held stable by the integrator.
- `Y`, out, WIDTH: filtered output, signed, registered.
- `Done`, out, 1: one-cycle pulse when `Y` updates.
- `Busy`, out, 1: high whenever the FSM is not in IDLE (decoded from the state register).
- `Overrun`, out, 1: sticky flag; set when `Enable` arrives while busy.

## Operation

- Delay line `x0..x3` holds WIDTH-bit signed values; `x0` is the newest sample.
- Output: y = A0·x0 + A1·x1 + A2·x2 + A3·x3.
- FSM states and transitions:
  - IDLE: `Enable`=1 → shift `x3<=x2`, `x2<=x1`, `x1<=x0`, `x0<=X`; clear accumulator; clear tap index k; go to MAC. `Enable`=0 → stay in IDLE.
  - MAC: acc <= acc + Ak·xk (k uses the already-shifted delay line); k <= k+1. After k=3 is accumulated, go to DONE.
  - DONE: `Y` <= sat(acc >>> FRAC); `Done` <= 1; go to IDLE.
- Arithmetic:
  - Each product is 2·WIDTH bits, signed.
  - Accumulator is 2·WIDTH+2 bits, signed; it cannot overflow.
  - Scaling is an arithmetic right shift by FRAC, i.e. truncation toward −∞. No rounding.
  - Saturation clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1]: −2048 to 2047 at defaults.
- Enable outside IDLE: ignored. The delay line is not shifted, the computation in progress is not disturbed, and `Overrun` <= 1.
- `Overrun` clears only on reset.
- Reset (`Reset`=0), including mid-MAC: immediately forces state IDLE, k=0, accumulator 0, delay line 0, `Y`=0, `Done`=0, `Overrun`=0. `Busy` reads 0.
- After `Reset` deasserts, the first `Enable` in IDLE starts a normal computation. No partial result from before the reset is ever output.

## Timing

- Edge numbering: E0 is the rising edge that samples `Enable`=1 in IDLE.
- E1–E4: accumulate taps 0–3.
- E5: `Y` updates and `Done` rises.
- `Done` is high between E5 and E6, exactly one cycle.
- `Busy` is high from after E0 until E5.
- Latency: 5 clocks from the sampling edge to valid `Y`.
- Earliest next accepted `Enable`: E5. An `Enable` sampled at E5 (state DONE) is ignored and sets `Overrun`. First accepting edge is E6.
- Minimum `Enable` spacing: 6 clocks. The divider's 1135-clock period is far above this.
- `Y` holds its value between `Done` pulses.

## Test plan

- Reset value check: assert `Reset`=0 asynchronously between edges → `Y`=0, `Done`=0, `Busy`=0, `Overrun`=0 immediately, without waiting for a clock edge.
- Impulse response (defaults):
  - Setup: `A0`=128, `A1`=64, `A2`=−64, `A3`=256; drive `X`=256, then `X`=0 for four more strobes.
  - Required `Y` sequence: 128, 64, −64, 256, 0.
  - Each `Done` appears exactly 5 clocks after its strobe edge.
- Saturation and truncation:
  - All coefficients 256, four strobes of `X`=2047 → `Y`=2047.
  - All coefficients 256, four strobes of `X`=−2048 → `Y`=−2048.
  - `A0`=1, others 0, `X`=−1 → `Y`=−1 (floor behaviour).
- Overrun:
  - Pulse `Enable` at E2, and separately at E5, of a computation → `Y` matches the undisturbed result.
  - Delay line is not shifted; `Overrun`=1 and stays 1 until reset.
- Reset mid-operation:
  - Drop `Reset` between E2 and E3 → no `Done`; `Y`=0.
  - A following impulse test with `X`=256, `A0`=128 yields `Y`=128: zeroed history, no stale taps.
- Integration with the divider:
  - Drive `Enable` from the divider (period 1135 clocks).
  - Feed a constant `X`=256 with `A0..A3`=64 → after the fourth `Done`, `Y`=256 steady.
  - `Overrun` stays 0 throughout.

Source files
------------

// File: rtl/filtro_fir.sv
// Four-tap signed fixed-point FIR stage: one sample per Enable strobe, serial MAC with one tap per clock, saturated output.
// Latency: 5 clocks from the edge that samples Enable to Y/Done (E0 capture, E1-E4 accumulate, E5 output).
// Backpressure: none; an Enable outside IDLE is dropped, and the sticky Overrun flag records it.
//
// Ports:
//   CLK      clock, rising edge
//   Reset    asynchronous active-low reset
//   Enable   one-cycle sample strobe; accepted only while idle
//   X        input sample, signed Q(WIDTH-FRAC).FRAC
//   A0..A3   tap coefficients, signed Q(WIDTH-FRAC).FRAC, held stable
//   Y        registered, saturated filter output
//   Done     one-cycle pulse when Y updates
//   Busy     high whenever a computation is in flight
//   Overrun  sticky; set by an Enable that arrives while busy
module filtro_fir #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 8
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] A0,
  input  logic signed [WIDTH-1:0] A1,
  input  logic signed [WIDTH-1:0] A2,
  input  logic signed [WIDTH-1:0] A3,
  output logic signed [WIDTH-1:0] Y,
  output logic                    Done,
  output logic                    Busy,
  output logic                    Overrun
);

  localparam int PW = 2 * WIDTH;      // product width
  localparam int AW = 2 * WIDTH + 2;  // accumulator width: four products cannot overflow it

  // Output clamp bounds, sign-extended to the accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        [1:0]       k;
  logic signed [WIDTH-1:0] x_dl [4];   // x_dl[0] is the newest sample
  logic signed [AW-1:0]    acc;

  logic signed [WIDTH-1:0] coef_k;
  logic signed [WIDTH-1:0] tap_k;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc_sh;
  logic signed [WIDTH-1:0] y_sat;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Enable) state_nxt = S_MAC;
      S_MAC:   if (k == 2'd3) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Busy = (state != S_IDLE);

  // ---------------- Datapath ----------------
  always_comb begin
    coef_k = A0;
    tap_k  = x_dl[0];
    case (k)
      2'd0: begin coef_k = A0; tap_k = x_dl[0]; end
      2'd1: begin coef_k = A1; tap_k = x_dl[1]; end
      2'd2: begin coef_k = A2; tap_k = x_dl[2]; end
      2'd3: begin coef_k = A3; tap_k = x_dl[3]; end
      default: begin coef_k = A0; tap_k = x_dl[0]; end
    endcase
  end

  // Sign-extend both operands so the multiply is done at full product width.
  assign prod = PW'(coef_k) * PW'(tap_k);

  // Arithmetic shift floors toward -inf; no rounding term is added on purpose.
  assign acc_sh = acc >>> FRAC;

  always_comb begin
    y_sat = acc_sh[WIDTH-1:0];
    if (acc_sh > SAT_MAX) begin
      y_sat = SAT_MAX[WIDTH-1:0];
    end else if (acc_sh < SAT_MIN) begin
      y_sat = SAT_MIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) x_dl[i] <= '0;
      acc     <= '0;
      k       <= '0;
      Y       <= '0;
      Done    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Done <= 1'b0;

      // A strobe during a computation is dropped but remembered until reset.
      if (Enable && (state != S_IDLE)) begin
        Overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (Enable) begin
            x_dl[3] <= x_dl[2];
            x_dl[2] <= x_dl[1];
            x_dl[1] <= x_dl[0];
            x_dl[0] <= X;
            acc     <= '0;
            k       <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + AW'(prod);
          k   <= k + 2'd1;
        end
        S_DONE: begin
          Y    <= y_sat;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
